sram_wr_arbiter: RTL and testbench

- Shares the SRAM write ports among the 16 switch input ports.
- Each input port presents one ECC-encoded 136-bit page write (128 data bits plus 8 code bits) targeting one SRAM bank.
- Per bank, the block picks one requester per cycle by round-robin, returns a same-cycle grant, and drives a registered write to the bank.
- Sits between the per-port write buffers / ECC encoders and the SRAM bank array in the controller.

---
 rtl/hydra_pkg.sv | 23 ++
 rtl/sram_wr_arbiter_rr_pick.sv | 30 +++
 rtl/sram_wr_arbiter.sv | 111 +++++++++++
 tb/tb_sram_wr_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hydra_pkg.sv
// Shared sizes and request record for the SRAM write arbiter.
// It also holds the saturating counter helper.
package hydra_pkg;

  localparam int PORT_NUM = 16;
  localparam int SRAM_NUM = 32;
  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 136;
  localparam int SEL_W    = $clog2(SRAM_NUM);
  localparam int PIDX_W   = $clog2(PORT_NUM);
  localparam int CNT_W    = 16;

  typedef struct packed {
    logic [SEL_W-1:0]  sram;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } page_wr_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sram_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i wins.
// Index arithmetic wraps naturally because PORT_NUM is a power of two.
module rr_pick
  import hydra_pkg::*;
(
  input  logic [PORT_NUM-1:0] req_i,
  input  logic [PIDX_W-1:0]   ptr_i,
  output logic [PORT_NUM-1:0] gnt_o,
  output logic [PIDX_W-1:0]   idx_o,
  output logic                any_o
);

  logic [PIDX_W-1:0] p;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    p     = '0;
    for (int k = 0; k < PORT_NUM; k++) begin
      p = ptr_i + PIDX_W'(k);
      if (!any_o && req_i[p]) begin
        any_o = 1'b1;
        idx_o = p;
      end
    end
    gnt_o[idx_o] = any_o;
  end

endmodule

// File: rtl/sram_wr_arbiter.sv
// Per-bank round-robin arbitration of port page writes onto the SRAM write ports.
// Grants are same-cycle; the bank write is registered one cycle later.
module sram_wr_arbiter
  import hydra_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PORT_NUM-1:0]              port_req,
  input  logic [PORT_NUM-1:0][SEL_W-1:0]   port_sram,
  input  logic [PORT_NUM-1:0][ADDR_W-1:0]  port_addr,
  input  logic [PORT_NUM-1:0][DATA_W-1:0]  port_data,
  output logic [PORT_NUM-1:0]              port_gnt,
  input  logic [SRAM_NUM-1:0]              sram_busy,
  output logic [SRAM_NUM-1:0]              sram_wr_en,
  output logic [SRAM_NUM-1:0][ADDR_W-1:0]  sram_wr_addr,
  output logic [SRAM_NUM-1:0][DATA_W-1:0]  sram_wr_data,
  output logic [CNT_W-1:0]                 conflict_cnt
);

  page_wr_t                          req_s    [PORT_NUM];
  logic [PORT_NUM-1:0]               bank_req [SRAM_NUM];
  logic [PORT_NUM-1:0]               bank_gnt [SRAM_NUM];
  logic [SRAM_NUM-1:0][PIDX_W-1:0]   bank_idx;
  logic [SRAM_NUM-1:0]               bank_any;
  logic [PORT_NUM-1:0]               gnt_all;
  logic [PORT_NUM-1:0]               tgt_busy;
  logic                              lost;

  logic [SRAM_NUM-1:0][PIDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SRAM_NUM-1:0]               wr_en_q, wr_en_d;
  logic [SRAM_NUM-1:0][ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [SRAM_NUM-1:0][DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;

  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      req_s[p] = '{sram: port_sram[p], addr: port_addr[p], data: port_data[p]};
    end
  end

  // A busy bank simply sees no candidates, which also freezes its pointer.
  always_comb begin
    for (int b = 0; b < SRAM_NUM; b++) begin
      bank_req[b] = '0;
      for (int p = 0; p < PORT_NUM; p++) begin
        bank_req[b][p] = port_req[p] && (req_s[p].sram == SEL_W'(b)) && !sram_busy[b];
      end
    end
  end

  for (genvar b = 0; b < SRAM_NUM; b++) begin : g_bank
    rr_pick u_pick (
      .req_i (bank_req[b]),
      .ptr_i (rr_ptr_q[b]),
      .gnt_o (bank_gnt[b]),
      .idx_o (bank_idx[b]),
      .any_o (bank_any[b])
    );
  end

  always_comb begin
    gnt_all  = '0;
    tgt_busy = '0;
    for (int b = 0; b < SRAM_NUM; b++) begin
      gnt_all = gnt_all | bank_gnt[b];
    end
    for (int p = 0; p < PORT_NUM; p++) begin
      tgt_busy[p] = sram_busy[req_s[p].sram];
    end
    lost     = |(port_req & ~gnt_all & ~tgt_busy);
    port_gnt = rst ? '0 : gnt_all;
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = bank_any;
    cnt_d     = lost ? sat_inc(cnt_q) : cnt_q;
    for (int b = 0; b < SRAM_NUM; b++) begin
      if (bank_any[b]) begin
        rr_ptr_d[b]  = bank_idx[b] + 1'b1;
        wr_addr_d[b] = req_s[bank_idx[b]].addr;
        wr_data_d[b] = req_s[bank_idx[b]].data;
      end
    end
  end

  // Registered bank write stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sram_wr_en   = wr_en_q;
  assign sram_wr_addr = wr_addr_q;
  assign sram_wr_data = wr_data_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sram_wr_arbiter.sv
// Scoreboard bench for sram_wr_arbiter: a round-robin reference model predicts
// grants, queued bank writes and the conflict counter.
module tb_sram_wr_arbiter;
  import hydra_pkg::*;

  logic                             clk = 1'b0;
  logic                             rst;
  logic [PORT_NUM-1:0]              port_req;
  logic [PORT_NUM-1:0][SEL_W-1:0]   port_sram;
  logic [PORT_NUM-1:0][ADDR_W-1:0]  port_addr;
  logic [PORT_NUM-1:0][DATA_W-1:0]  port_data;
  logic [PORT_NUM-1:0]              port_gnt;
  logic [SRAM_NUM-1:0]              sram_busy;
  logic [SRAM_NUM-1:0]              sram_wr_en;
  logic [SRAM_NUM-1:0][ADDR_W-1:0]  sram_wr_addr;
  logic [SRAM_NUM-1:0][DATA_W-1:0]  sram_wr_data;
  logic [CNT_W-1:0]                 conflict_cnt;

  sram_wr_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .port_req     (port_req),
    .port_sram    (port_sram),
    .port_addr    (port_addr),
    .port_data    (port_data),
    .port_gnt     (port_gnt),
    .sram_busy    (sram_busy),
    .sram_wr_en   (sram_wr_en),
    .sram_wr_addr (sram_wr_addr),
    .sram_wr_data (sram_wr_data),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                bank;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_wr_t;

  exp_wr_t             wq[$];
  logic [SRAM_NUM-1:0] enq[$];
  int                  mptr [SRAM_NUM];
  logic [CNT_W-1:0]    mcnt;
  bit                  persist [PORT_NUM];
  int                  ntot = 0;
  int                  npass = 0;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ntot++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [DATA_W-1:0] rnd_page();
    return DATA_W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  task automatic add_req(input int p, input int b, input bit pers);
    port_req[p]  = 1'b1;
    port_sram[p] = SEL_W'(b);
    port_addr[p] = ADDR_W'($urandom());
    port_data[p] = rnd_page();
    persist[p]   = pers;
  endtask

  task automatic model_reset();
    for (int b = 0; b < SRAM_NUM; b++) mptr[b] = 0;
    mcnt = '0;
    wq.delete();
    enq.delete();
  endtask

  // One clock: predict and check grants, push expected writes, cross the edge,
  // pop and check writes and counter, then apply the requester handshake.
  task automatic cycle(input bit ck);
    logic [PORT_NUM-1:0] eg;
    logic [SRAM_NUM-1:0] een;
    logic [SRAM_NUM-1:0] gen;
    int                  win [SRAM_NUM];
    bit                  lost;
    int                  p;
    exp_wr_t             e;
    #1;
    eg = '0; een = '0; lost = 0;
    for (int b = 0; b < SRAM_NUM; b++) begin
      win[b] = 0;
      if (!sram_busy[b]) begin
        for (int k = 0; k < PORT_NUM; k++) begin
          p = (mptr[b] + k) % PORT_NUM;
          if (!een[b] && port_req[p] && int'(port_sram[p]) == b) begin
            een[b] = 1'b1; eg[p] = 1'b1; win[b] = p;
          end
        end
      end
    end
    for (int q = 0; q < PORT_NUM; q++)
      if (port_req[q] && !sram_busy[port_sram[q]] && !eg[q]) lost = 1;
    if (ck) check_val("gnt", 256'(port_gnt), 256'(eg));
    for (int b = 0; b < SRAM_NUM; b++)
      if (een[b]) wq.push_back('{b, port_addr[win[b]], port_data[win[b]]});
    enq.push_back(een);
    @(posedge clk); #1;
    for (int b = 0; b < SRAM_NUM; b++)
      if (een[b]) mptr[b] = (win[b] + 1) % PORT_NUM;
    if (lost && mcnt != 16'hFFFF) mcnt = mcnt + 1'b1;
    gen = enq.pop_front();
    if (ck) check_val("wr_en", 256'(sram_wr_en), 256'(gen));
    for (int b = 0; b < SRAM_NUM; b++) begin
      if (gen[b]) begin
        e = wq.pop_front();
        if (ck) begin
          check_val($sformatf("wr_addr[%0d]", e.bank), 256'(sram_wr_addr[e.bank]), 256'(e.addr));
          check_val($sformatf("wr_data[%0d]", e.bank), 256'(sram_wr_data[e.bank]), 256'(e.data));
        end
      end
    end
    if (ck) check_val("conflict_cnt", 256'(conflict_cnt), 256'(mcnt));
    for (int q = 0; q < PORT_NUM; q++) begin
      if (eg[q]) begin
        if (persist[q]) begin
          port_addr[q] = ADDR_W'($urandom());
          port_data[q] = rnd_page();
        end else begin
          port_req[q] = 1'b0;
        end
      end
    end
  endtask

  int                  seq1 [9] = '{0, 3, 9, 0, 3, 9, 0, 3, 9};
  logic [CNT_W-1:0]    cnt_before;
  logic [PORT_NUM-1:0] one_hot;

  initial begin
    rst = 1'b1;
    port_req = '0; port_sram = '0; port_addr = '0; port_data = '0; sram_busy = '0;
    for (int q = 0; q < PORT_NUM; q++) persist[q] = 0;
    model_reset();
    port_req[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_gnt", 256'(port_gnt), 256'(0));
    check_val("rst_wr_en", 256'(sram_wr_en), 256'(0));
    check_val("rst_wr_addr5", 256'(sram_wr_addr[5]), 256'(0));
    check_val("rst_cnt", 256'(conflict_cnt), 256'(0));
    port_req = '0;
    rst = 1'b0;

    // Three persistent requesters on bank 5, then let them drain one by one.
    add_req(0, 5, 1); add_req(3, 5, 1); add_req(9, 5, 1);
    for (int i = 0; i < 9; i++) begin
      if (i == 6) begin persist[0] = 0; persist[3] = 0; persist[9] = 0; end
      #1;
      one_hot = '0; one_hot[seq1[i]] = 1'b1;
      check_val("rr_order", 256'(port_gnt), 256'(one_hot));
      cycle(1);
    end
    check_val("cnt_after_rr", 256'(conflict_cnt), 256'(8));

    // Wrap: move bank 2 pointer to 15, then ports 15 and 0 contend.
    add_req(14, 2, 0);
    cycle(1);
    add_req(15, 2, 0); add_req(0, 2, 0);
    #1; check_val("wrap_first", 256'(port_gnt), 256'(16'h8000));
    cycle(1);
    #1; check_val("wrap_second", 256'(port_gnt), 256'(16'h0001));
    cycle(1);
    add_req(0, 2, 0); add_req(1, 2, 0);
    #1; check_val("ptr_at_1", 256'(port_gnt), 256'(16'h0002));
    cycle(1);
    cycle(1);

    // All sixteen ports to distinct banks in one cycle.
    for (int q = 0; q < PORT_NUM; q++) add_req(q, q, 0);
    cnt_before = mcnt;
    #1; check_val("all_gnt", 256'(port_gnt), 256'(16'hFFFF));
    cycle(1);
    check_val("all_wr_en", 256'(sram_wr_en), 256'(32'h0000FFFF));
    check_val("all_cnt", 256'(conflict_cnt), 256'(cnt_before));

    // Busy bank holds off the request for three cycles.
    add_req(4, 7, 0);
    sram_busy[7] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1);
      check_val("busy_no_wr", 256'(sram_wr_en[7]), 256'(0));
    end
    sram_busy[7] = 1'b0;
    #1; check_val("busy_release_gnt", 256'(port_gnt), 256'(16'h0010));
    cycle(1);
    check_val("busy_write", 256'(sram_wr_en[7]), 256'(1));
    cycle(1);

    // Reset between a grant and its write edge.
    add_req(2, 20, 0); add_req(5, 20, 0);
    cycle(1);
    add_req(2, 20, 0);
    #1; check_val("pre_rst_gnt", 256'(port_gnt), 256'(16'h0020));
    rst = 1'b1;
    #1;
    check_val("mid_rst_wr_en", 256'(sram_wr_en), 256'(0));
    check_val("mid_rst_cnt", 256'(conflict_cnt), 256'(0));
    check_val("mid_rst_gnt", 256'(port_gnt), 256'(0));
    model_reset();
    rst = 1'b0;
    #1; check_val("post_rst_gnt", 256'(port_gnt), 256'(16'h0004));
    cycle(1);
    cycle(1);
    cycle(1);

    // Counter saturation under persistent contention.
    rst = 1'b1; #2; rst = 1'b0;
    model_reset();
    add_req(0, 1, 1); add_req(1, 1, 1);
    for (int i = 0; i < 65534; i++) cycle(0);
    check_val("cnt_fffe", 256'(conflict_cnt), 256'(16'hFFFE));
    for (int i = 0; i < 3; i++) cycle(1);
    check_val("cnt_sat", 256'(conflict_cnt), 256'(16'hFFFF));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
